// File: rtl/fadd_norm_round_if.sv
// fadd_norm_round_if: handshake bundle for the normalize-and-round stage.
// Input side carries the unnormalized adder sum; output side carries the
// packed binary32 result and its status flags.
interface fadd_norm_round_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [26:0] in_mant;
   logic        in_sticky;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_inexact;

   // Producer of sums and consumer of results
   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );

   // The normalize-and-round stage itself
   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );
endinterface

// File: rtl/fadd_norm_round.sv
// fadd_norm_round: normalizes an unnormalized signed-magnitude significand sum
// one bit per cycle, rounds to nearest-even and packs an IEEE-754 single.
// Optional feature macro FPU_DENORM_EN: when defined, results below the
// normal range are emitted as subnormals; otherwise they flush to zero.
module fadd_norm_round (
   input  logic             clk,
   input  logic             rst,
   fadd_norm_round_if.slave bus
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [26:0]        mant_q, mant_d;
   logic               sticky_q, sticky_d;
   logic [4:0]         lsh_q, lsh_d;
   logic [31:0]        res_q, res_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               inx_q, inx_d;
   logic               shl_ok;
   logic [22:0]        spec_frac;

   // Round-to-nearest-even on mant[26:2] with guard mant[1] and round mant[0]|sticky,
   // then pack; returns {result[31:0], overflow, underflow, inexact}.
   function automatic logic [34:0] round_pack(input logic              sign,
                                              input logic signed [9:0] exp,
                                              input logic [26:0]       mant,
                                              input logic              sticky);
      logic              g, r, up, carry, inx;
      logic [24:0]       m;
      logic [22:0]       frac;
      logic signed [9:0] e;
`ifdef FPU_DENORM_EN
      logic [7:0]        ef;
`endif
      g     = mant[1];
      r     = mant[0] | sticky;
      up    = g & (r | mant[2]);
      m     = mant[26:2] + {24'd0, up};
      carry = m[24];
      frac  = carry ? m[23:1] : m[22:0];
      e     = exp + (carry ? 10'sd1 : 10'sd0);
      inx   = g | r;
      if (e >= 10'sd255)
         return {sign, 8'hFF, 23'd0, 1'b1, 1'b0, 1'b1};
`ifdef FPU_DENORM_EN
      // No hidden bit left after rounding means the value is subnormal (or zero);
      // a rounding carry into the hidden bit naturally yields exponent field 1.
      ef = (~carry & ~m[23]) ? 8'd0 : e[7:0];
      return {sign, ef, frac, 1'b0, inx & (ef == 8'd0), inx};
`else
      if (e <= 10'sd0)
         return {sign, 31'd0, 1'b0, 1'b1, 1'b1};
      return {sign, e[7:0], frac, 1'b0, 1'b0, inx};
`endif
   endfunction

   // A left shift may only happen while the exponent can absorb it
`ifdef FPU_DENORM_EN
   assign shl_ok = (exp_q > 10'sd1) && (lsh_q < 5'd24);
`else
   assign shl_ok = (lsh_q < 5'd24);
`endif

   // NaN payloads are quieted by forcing the top fraction bit when nonzero
   assign spec_frac = bus.in_mant[24:2] | {(|bus.in_mant[24:2]), 22'd0};

   assign bus.in_ready      = (state_q == IDLE) & ~rst;
   assign bus.out_valid     = (state_q == DONE);
   assign bus.out_result    = res_q;
   assign bus.out_overflow  = ovf_q;
   assign bus.out_underflow = unf_q;
   assign bus.out_inexact   = inx_q;

   // Next-state and datapath decisions for each FSM state
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      sticky_d = sticky_q;
      lsh_d    = lsh_q;
      res_d    = res_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inx_d    = inx_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sign_d   = bus.in_sign;
               exp_d    = {2'b00, bus.in_exp};
               mant_d   = bus.in_mant;
               sticky_d = bus.in_sticky;
               lsh_d    = 5'd0;
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               inx_d    = 1'b0;
               if (bus.in_exp == 8'hFF) begin
                  res_d   = {bus.in_sign, 8'hFF, spec_frac};
                  state_d = DONE;
               end else if ((bus.in_mant == 27'd0) && !bus.in_sticky) begin
                  res_d   = {bus.in_sign, 31'd0};
                  state_d = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (mant_q[26]) begin
               mant_d   = {1'b0, mant_q[26:1]};
               sticky_d = sticky_q | mant_q[0];
               exp_d    = exp_q + 10'sd1;
               state_d  = ROUND;
            end else if (!mant_q[25] && shl_ok) begin
               mant_d = {mant_q[25:0], 1'b0};
               exp_d  = exp_q - 10'sd1;
               lsh_d  = lsh_q + 5'd1;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            {res_d, ovf_d, unf_d, inx_d} = round_pack(sign_q, exp_q, mant_q, sticky_q);
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         exp_q    <= 10'sd0;
         mant_q   <= 27'd0;
         sticky_q <= 1'b0;
         lsh_q    <= 5'd0;
         res_q    <= 32'd0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         sticky_q <= sticky_d;
         lsh_q    <= lsh_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         inx_q    <= inx_d;
      end
   end

endmodule

// File: tb/tb_fadd_norm_round.sv
// tb_fadd_norm_round: scoreboard bench for fadd_norm_round. A driver issues
// directed and random sums and queues the expected result; a monitor pops and
// compares whenever the stage presents a result.
module tb_fadd_norm_round;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fadd_norm_round_if bus();

   fadd_norm_round dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;   // {overflow, underflow, inexact}
      int          lat;   // -1: latency not checked
      int          e0;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ready_mode = 2;  // 0 random, 1 held low, 2 held high

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Reference: value-level normalize / round-to-nearest-even with integer arithmetic
   function automatic exp_t model(input bit s, input logic [7:0] ei, input logic [26:0] mi, input bit st);
      exp_t        x;
      int          e, k, p, need, cap;
      longint      m, q;
      bit          g, r, up, inx;
      logic [22:0] frac;
      logic [7:0]  ef;
      x.flg = 3'b000; x.lat = -1; x.e0 = 0;
      if (ei == 8'hFF) begin
         x.res = {s, 8'hFF, mi[24:2]};
         if (mi[24:2] != 23'd0) x.res[22] = 1'b1;
         return x;
      end
      if (mi == 27'd0 && !st) begin
         x.res = {s, 31'd0};
         return x;
      end
      e = int'(ei); m = longint'(mi); k = 0;
      if (m >= (longint'(1) << 26)) begin
         st = st | ((m % 2) != 0);
         m  = m / 2;
         e  = e + 1;
      end else begin
         p = -1;
         for (int i = 0; i < 26; i++) if (((m >> i) & 1) != 0) p = i;
         need = (p < 0) ? 24 : 25 - p;
         cap  = 24;
`ifdef FPU_DENORM_EN
         if (e - 1 < cap) cap = (e - 1 > 0) ? e - 1 : 0;
`endif
         k = (need < cap) ? need : cap;
         m = (m << k) % (longint'(1) << 27);
         e = e - k;
      end
      x.lat = k + 2;
      q   = m / 4;
      g   = ((m / 2) % 2) != 0;
      r   = ((m % 2) != 0) || st;
      up  = g && (r || (q % 2) != 0);
      inx = g || r;
      q   = q + (up ? 1 : 0);
      if (q >= (longint'(1) << 24)) begin
         q = q / 2;
         e = e + 1;
      end
      frac = q[22:0];
      if (e >= 255) begin
         x.res = {s, 8'hFF, 23'd0};
         x.flg = 3'b101;
         return x;
      end
`ifdef FPU_DENORM_EN
      ef    = (q < (longint'(1) << 23)) ? 8'd0 : e[7:0];
      x.res = {s, ef, frac};
      x.flg = {1'b0, inx && (ef == 8'd0), inx};
`else
      if (e <= 0) begin
         x.res = {s, 31'd0};
         x.flg = 3'b011;
      end else begin
         x.res = {s, e[7:0], frac};
         x.flg = {2'b00, inx};
      end
`endif
      return x;
   endfunction

   // Present one sum; the expectation is queued just before the accepting edge
   task automatic send(input bit s, input logic [7:0] e, input logic [26:0] m, input bit st,
                       input exp_t x, input bit push);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      bus.in_sign = s; bus.in_exp = e; bus.in_mant = m; bus.in_sticky = st;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL accept_timeout: got in_ready=0 want 1");
      end else begin
         x.e0 = cyc + 1;
         if (push) sb.push_back(x);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic dir(input bit s, input logic [7:0] e, input logic [26:0] m, input bit st,
                      input logic [31:0] res, input logic [2:0] flg, input int lat);
      exp_t x;
      x.res = res; x.flg = flg; x.lat = lat; x.e0 = 0;
      send(s, e, m, st, x, 1'b1);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
      end
   endtask

   // Consumer backpressure
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.out_ready = ($urandom % 4) != 0;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compare each new result, and hold-stability while stalled
   initial begin
      exp_t        x;
      logic [34:0] held;
      bit          seen;
      seen = 1'b0; held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen = 1'b0;
         end else if (bus.out_valid) begin
            if (!seen) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_out: got %0h want none", bus.out_result);
               end else begin
                  x = sb.pop_front();
                  check("result", bus.out_result, x.res);
                  check("flags", {bus.out_overflow, bus.out_underflow, bus.out_inexact}, x.flg);
                  if (x.lat >= 0) check("latency", cyc - x.e0, x.lat);
               end
               held = {bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_inexact};
               seen = 1'b1;
            end else begin
               check("stall_hold",
                     {bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_inexact}, held);
            end
            if (bus.out_ready) seen = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      exp_t        x;
      bit          s, st;
      logic [7:0]  e;
      logic [26:0] m;
      int          r, p;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = 8'd0;
      bus.in_mant = 27'd0; bus.in_sticky = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_result", bus.out_result, 32'd0);
      check("rst_flags", {bus.out_overflow, bus.out_underflow, bus.out_inexact}, 3'b000);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", bus.in_ready, 1'b1);

      // Directed vectors
      ready_mode = 2;
      dir(0, 8'd127, 27'h4000000, 0, 32'h40000000, 3'b000, 2);
      dir(0, 8'd127, 27'h0400000, 0, 32'h3E000000, 3'b000, 5);
      dir(0, 8'd127, 27'h2000002, 0, 32'h3F800000, 3'b001, 2);
      dir(0, 8'd127, 27'h2000006, 0, 32'h3F800002, 3'b001, 2);
      dir(0, 8'd127, 27'h2000003, 0, 32'h3F800001, 3'b001, 2);
      dir(0, 8'd254, 27'h4000000, 0, 32'h7F800000, 3'b101, 2);
      dir(0, 8'd255, 27'h0000004, 0, 32'h7FC00001, 3'b000, -1);
      dir(1, 8'd255, 27'h0000000, 0, 32'hFF800000, 3'b000, -1);
      dir(1, 8'd100, 27'h0000000, 0, 32'h80000000, 3'b000, -1);
`ifdef FPU_DENORM_EN
      dir(0, 8'd1, 27'h1000000, 0, 32'h00400000, 3'b000, 2);
`else
      dir(0, 8'd1, 27'h1000000, 0, 32'h00000000, 3'b011, 3);
`endif
      drain();

      // Backpressure: result must hold and no new input accepted
      ready_mode = 1;
      dir(0, 8'd127, 27'h2000006, 0, 32'h3F800002, 3'b001, 2);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", bus.in_ready, 1'b0);
         check("stall_out_valid", bus.out_valid, 1'b1);
      end
      ready_mode = 2;
      drain();

      // Reset while normalizing: result is discarded
      x = model(0, 8'd127, 27'h0400000, 0);
      send(0, 8'd127, 27'h0400000, 0, x, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", bus.out_valid, 1'b0);
      check("midrst_in_ready", bus.in_ready, 1'b0);
      check("midrst_result", bus.out_result, 32'd0);
      rst = 1'b0;
      #1;
      check("midrst_release_ready", bus.in_ready, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      check("no_stale_out", bus.out_valid, 1'b0);

      // Randomized sums against the reference model
      ready_mode = 0;
      for (int n = 0; n < 300; n++) begin
         r  = int'($urandom % 20);
         s  = $urandom % 2;
         st = $urandom % 2;
         if (r == 0)      e = 8'd255;
         else if (r < 3)  e = 8'(254 - ($urandom % 3));
         else if (r < 6)  e = 8'(1 + ($urandom % 30));
         else             e = 8'(1 + ($urandom % 254));
         p = 2 + int'($urandom % 25);
         m = 27'(($urandom & ((32'd1 << p) - 32'd1)) | (32'd1 << p));
         if (r == 19) m = 27'd0;
         x = model(s, e, m, st);
         send(s, e, m, st, x, 1'b1);
      end
      ready_mode = 2;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
